// File: rtl/gate_engine.sv
// gate_engine
//   Column-serial LSTM gate engine. Computes act(Wx*x + Wy*y + b) for all
//   HIDDEN_SZ rows in parallel. It streams one input element and one weight
//   column per cycle from two synchronous-read weight RAMs.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   beginCalc          start request, only honoured in IDLE
//   abort              synchronous abort; returns to IDLE without a result
//   useY               include the recurrent term (latched at start)
//   mode               activation: 00/11 linear, 01 hard-sigmoid, 10 hard-tanh
//   biasVec            per-row bias, row r at [r*BITWIDTH +: BITWIDTH]
//   inputVec           x[colAddressRead_X], one cycle after the address
//   prevOutVec         y[colAddressRead_Y], one cycle after the address
//   weightMemOutput_X  column of Wx, one cycle after the address
//   weightMemOutput_Y  column of Wy, one cycle after the address
//   colAddressRead_X   Wx/x column address (0 outside RUN_X)
//   colAddressRead_Y   Wy/y column address (0 outside RUN_Y)
//   busy               high from the start edge through the dataReady cycle
//   dataReady          one-cycle pulse when gateOutput is updated
//   gateOutput         registered, saturated and activated result
module gate_engine #(
  parameter int INPUT_SZ  = 4,
  parameter int HIDDEN_SZ = 32,
  parameter int QN        = 7,
  parameter int QM        = 10,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int AX             = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1,
  localparam int AY             = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginCalc,
  input  logic                      abort,
  input  logic                      useY,
  input  logic [1:0]                mode,
  input  logic [LAYER_BITWIDTH-1:0] biasVec,
  input  logic [BITWIDTH-1:0]       inputVec,
  input  logic [BITWIDTH-1:0]       prevOutVec,
  input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_X,
  input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_Y,
  output logic [AX-1:0]             colAddressRead_X,
  output logic [AY-1:0]             colAddressRead_Y,
  output logic                      busy,
  output logic                      dataReady,
  output logic [LAYER_BITWIDTH-1:0] gateOutput
);

  // Accumulator holds the full-precision sum of every column plus the bias.
  localparam int ACCW = 2 * BITWIDTH + $clog2(INPUT_SZ + HIDDEN_SZ);

  localparam logic signed [ACCW-1:0]     SAT_HI_W = ACCW'((2 ** (BITWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0]     SAT_LO_W = ACCW'(-(2 ** (BITWIDTH - 1)));
  localparam logic signed [BITWIDTH-1:0] OUT_MAX  = BITWIDTH'((2 ** (BITWIDTH - 1)) - 1);
  localparam logic signed [BITWIDTH-1:0] OUT_MIN  = BITWIDTH'(-(2 ** (BITWIDTH - 1)));
  localparam logic signed [BITWIDTH-1:0] ONE_V    = BITWIDTH'(2 ** QM);
  localparam logic signed [BITWIDTH-1:0] NEG_ONE  = BITWIDTH'(-(2 ** QM));
  localparam logic signed [BITWIDTH+1:0] ONE_X    = (BITWIDTH + 2)'(2 ** QM);
  localparam logic signed [BITWIDTH+1:0] HALF_X   = (BITWIDTH + 2)'(2 ** (QM - 1));

  typedef enum logic [2:0] {IDLE, RUN_X, RUN_Y, DRAIN, FINISH} stateType;

  stateType                  state;
  logic [1:0]                modeReg;
  logic                      useYReg;
  logic                      colValid;   // RAM data on the inputs belongs to a live column
  logic                      colIsY;     // that column is a recurrent (Y) column
  logic                      startCalc;
  logic [LAYER_BITWIDTH-1:0] actOut;

  assign startCalc = (state == IDLE) && beginCalc && !abort;

  // Control FSM. The address registered at edge k is read by the RAM at k+1,
  // so colValid (set while an address is live) lines up with the data at k+2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      colAddressRead_X <= '0;
      colAddressRead_Y <= '0;
      busy             <= 1'b0;
      dataReady        <= 1'b0;
      gateOutput       <= '0;
      modeReg          <= 2'b00;
      useYReg          <= 1'b0;
      colValid         <= 1'b0;
      colIsY           <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      colValid  <= 1'b0;
      if (abort) begin
        state            <= IDLE;
        colAddressRead_X <= '0;
        colAddressRead_Y <= '0;
        busy             <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= beginCalc;
            if (beginCalc) begin
              state            <= RUN_X;
              colAddressRead_X <= '0;
              modeReg          <= mode;
              useYReg          <= useY;
            end
          end
          RUN_X: begin
            colValid <= 1'b1;
            colIsY   <= 1'b0;
            if (colAddressRead_X == AX'(INPUT_SZ - 1)) begin
              colAddressRead_X <= '0;
              state            <= useYReg ? RUN_Y : DRAIN;
            end else begin
              colAddressRead_X <= colAddressRead_X + 1'b1;
            end
          end
          RUN_Y: begin
            colValid <= 1'b1;
            colIsY   <= 1'b1;
            if (colAddressRead_Y == AY'(HIDDEN_SZ - 1)) begin
              colAddressRead_Y <= '0;
              state            <= DRAIN;
            end else begin
              colAddressRead_Y <= colAddressRead_Y + 1'b1;
            end
          end
          DRAIN: state <= FINISH;
          FINISH: begin
            gateOutput <= actOut;
            dataReady  <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Per-row datapath: multiply-accumulate, then rescale, saturate and activate.
  for (genvar gi = 0; gi < HIDDEN_SZ; gi++) begin : gRow
    logic signed [ACCW-1:0]       acc;
    logic signed [ACCW-1:0]       biasExt;
    logic signed [ACCW-1:0]       shifted;
    logic signed [BITWIDTH-1:0]   wSel;
    logic signed [BITWIDTH-1:0]   vSel;
    logic signed [2*BITWIDTH-1:0] prod;
    logic signed [BITWIDTH-1:0]   satVal;
    logic signed [BITWIDTH+1:0]   satExt;
    logic signed [BITWIDTH+1:0]   sigPre;
    logic signed [BITWIDTH-1:0]   actVal;

    assign wSel    = colIsY ? $signed(weightMemOutput_Y[gi*BITWIDTH +: BITWIDTH])
                            : $signed(weightMemOutput_X[gi*BITWIDTH +: BITWIDTH]);
    assign vSel    = colIsY ? $signed(prevOutVec) : $signed(inputVec);
    assign prod    = wSel * vSel;
    assign biasExt = ACCW'($signed(biasVec[gi*BITWIDTH +: BITWIDTH]));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        acc <= '0;
      end else if (startCalc) begin
        acc <= biasExt <<< QM;   // bias aligned to the product's 2*QM fraction
      end else if (colValid) begin
        acc <= acc + ACCW'(prod);
      end
    end

    assign shifted = acc >>> QM;   // arithmetic shift floors toward -inf

    always_comb begin
      satVal = shifted[BITWIDTH-1:0];
      if (shifted > SAT_HI_W) begin
        satVal = OUT_MAX;
      end else if (shifted < SAT_LO_W) begin
        satVal = OUT_MIN;
      end
      // Two guard bits keep s/4 + 0.5 from wrapping before the clamp.
      satExt = {{2{satVal[BITWIDTH-1]}}, satVal};
      sigPre = (satExt >>> 2) + HALF_X;
      actVal = satVal;
      case (modeReg)
        2'b01: begin
          if (sigPre[BITWIDTH+1]) begin
            actVal = '0;
          end else if (sigPre > ONE_X) begin
            actVal = ONE_V;
          end else begin
            actVal = sigPre[BITWIDTH-1:0];
          end
        end
        2'b10: begin
          if (satVal < NEG_ONE) begin
            actVal = NEG_ONE;
          end else if (satVal > ONE_V) begin
            actVal = ONE_V;
          end
        end
        default: actVal = satVal;
      endcase
    end

    assign actOut[gi*BITWIDTH +: BITWIDTH] = actVal;
  end

endmodule

// File: tb/tb_gate_engine.sv
// tb_gate_engine
//   Scoreboard bench for gate_engine. The stimulus pushes the expected
//   result and completion cycle of each run. A negedge monitor pops that
//   entry on dataReady and compares it with the DUT output. The RAM pair is
//   modelled as registered-read arrays.
module tb_gate_engine;
  localparam int INPUT_SZ  = 4;
  localparam int HIDDEN_SZ = 32;
  localparam int QN        = 7;
  localparam int QM        = 10;
  localparam int BW        = QN + QM + 1;
  localparam int LBW       = BW * HIDDEN_SZ;
  localparam int AX        = (INPUT_SZ > 1) ? $clog2(INPUT_SZ) : 1;
  localparam int AY        = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;

  logic           clock;
  logic           reset;
  logic           beginCalc;
  logic           abort;
  logic           useY;
  logic [1:0]     mode;
  logic [LBW-1:0] biasVec;
  logic [BW-1:0]  inputVec;
  logic [BW-1:0]  prevOutVec;
  logic [LBW-1:0] weightMemOutput_X;
  logic [LBW-1:0] weightMemOutput_Y;
  logic [AX-1:0]  colAddressRead_X;
  logic [AY-1:0]  colAddressRead_Y;
  logic           busy;
  logic           dataReady;
  logic [LBW-1:0] gateOutput;

  gate_engine #(.INPUT_SZ(INPUT_SZ), .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM)) dut (
    .clock(clock), .reset(reset), .beginCalc(beginCalc), .abort(abort),
    .useY(useY), .mode(mode), .biasVec(biasVec), .inputVec(inputVec),
    .prevOutVec(prevOutVec), .weightMemOutput_X(weightMemOutput_X),
    .weightMemOutput_Y(weightMemOutput_Y), .colAddressRead_X(colAddressRead_X),
    .colAddressRead_Y(colAddressRead_Y), .busy(busy), .dataReady(dataReady),
    .gateOutput(gateOutput)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference contents of the weight RAMs, input vectors and biases.
  int wx [HIDDEN_SZ][INPUT_SZ];
  int wy [HIDDEN_SZ][HIDDEN_SZ];
  int xs [INPUT_SZ];
  int ys [HIDDEN_SZ];
  int bs [HIDDEN_SZ];

  typedef struct {
    logic [LBW-1:0] vec;
    int             doneCyc;
  } expType;

  expType         expQ[$];
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  logic [LBW-1:0] modelOut = '0;
  bit             prevDr = 1'b0;

  // Synchronous-read RAMs: the data for an address appears one edge later.
  always @(posedge clock) begin
    cyc        <= cyc + 1;
    inputVec   <= BW'(xs[colAddressRead_X]);
    prevOutVec <= BW'(ys[colAddressRead_Y]);
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      weightMemOutput_X[r*BW +: BW] <= BW'(wx[r][colAddressRead_X]);
      weightMemOutput_Y[r*BW +: BW] <= BW'(wy[r][colAddressRead_Y]);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkVec(input string name, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int r = 0; r < HIDDEN_SZ; r++) begin
        if (act[r*BW +: BW] !== exp[r*BW +: BW]) begin
          $display("FAIL %s: row %0d got 0x%05h, expected 0x%05h", name, r, act[r*BW +: BW], exp[r*BW +: BW]);
          break;
        end
      end
    end
  endtask

  task automatic checkAllRows(input string name, input logic [BW-1:0] ev);
    logic [LBW-1:0] e;
    for (int r = 0; r < HIDDEN_SZ; r++) e[r*BW +: BW] = ev;
    checkVec(name, gateOutput, e);
  endtask

  // Behavioural reference: exact integer dot products, then floor, clamp, activate.
  function automatic logic [LBW-1:0] model(input bit uy, input logic [1:0] md);
    logic [LBW-1:0] res;
    longint t, s, a;
    longint lo, hi, one;
    lo  = -(longint'(1) <<< (BW - 1));
    hi  = (longint'(1) <<< (BW - 1)) - 1;
    one = longint'(1) <<< QM;
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      t = longint'(bs[r]) * one;
      for (int c = 0; c < INPUT_SZ; c++) t += longint'(wx[r][c]) * longint'(xs[c]);
      if (uy) for (int c = 0; c < HIDDEN_SZ; c++) t += longint'(wy[r][c]) * longint'(ys[c]);
      s = t >>> QM;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      case (md)
        2'b01: begin
          a = (s >>> 2) + one / 2;
          if (a < 0) a = 0;
          if (a > one) a = one;
        end
        2'b10: begin
          a = s;
          if (a < -one) a = -one;
          if (a > one) a = one;
        end
        default: a = s;
      endcase
      res[r*BW +: BW] = BW'(a);
    end
    return res;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic fillConst(input int w, input int xv, input int wyv, input int yv, input int b);
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      bs[r] = b;
      for (int c = 0; c < INPUT_SZ; c++) wx[r][c] = w;
      for (int c = 0; c < HIDDEN_SZ; c++) wy[r][c] = wyv;
    end
    for (int c = 0; c < INPUT_SZ; c++) xs[c] = xv;
    for (int c = 0; c < HIDDEN_SZ; c++) ys[c] = yv;
  endtask

  task automatic fillRandom();
    for (int r = 0; r < HIDDEN_SZ; r++) begin
      bs[r] = rnd(-131072, 131071);
      for (int c = 0; c < INPUT_SZ; c++) wx[r][c] = rnd(-2048, 2047);
      for (int c = 0; c < HIDDEN_SZ; c++) wy[r][c] = rnd(-2048, 2047);
    end
    for (int c = 0; c < INPUT_SZ; c++) xs[c] = rnd(-2048, 2047);
    for (int c = 0; c < HIDDEN_SZ; c++) ys[c] = rnd(-2048, 2047);
  endtask

  // Called just after a negedge while the DUT is idle. Returns 1 ns after E0
  // and then scrambles the start-time inputs, which must no longer matter.
  task automatic startRun(input bit uy, input logic [1:0] md, input bit doPush);
    expType e;
    useY      = uy;
    mode      = md;
    for (int r = 0; r < HIDDEN_SZ; r++) biasVec[r*BW +: BW] = BW'(bs[r]);
    beginCalc = 1'b1;
    if (doPush) begin
      e.vec     = model(uy, md);
      e.doneCyc = cyc + 1 + (INPUT_SZ + (uy ? HIDDEN_SZ : 0)) + 2;
      expQ.push_back(e);
    end
    @(posedge clock);
    #1;
    beginCalc = 1'b0;
    useY      = 1'($urandom);
    mode      = 2'($urandom);
    for (int r = 0; r < HIDDEN_SZ; r++) biasVec[r*BW +: BW] = BW'($urandom);
  endtask

  // Count busy cycles until busy drops, bounded so a stuck DUT still finishes.
  task automatic waitDone(output int busyCnt, output bit yTouched);
    bit done = 1'b0;
    busyCnt  = 0;
    yTouched = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (colAddressRead_Y != '0) yTouched = 1'b1;
      if (busy) busyCnt++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("busy_timeout", 0, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    expType e;
    if (reset && dataReady) begin
      check("dataReady_single_cycle", longint'(prevDr), 0);
      check("dataReady_expected", longint'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("result_latency", cyc, e.doneCyc);
        checkVec("result_value", gateOutput, e.vec);
        modelOut = e.vec;
      end
    end
    prevDr = dataReady;
  end

  initial begin
    int  bc;
    bit  yt;
    bit  seen;
    bit  uy;
    logic [1:0] md;

    reset = 1'b0; beginCalc = 1'b0; abort = 1'b0; useY = 1'b0; mode = 2'b00;
    biasVec = '0;
    fillConst(0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    checkVec("reset_gateOutput", gateOutput, '0);
    check("reset_busy", busy, 0);
    check("reset_dataReady", dataReady, 0);
    reset = 1'b1;
    @(negedge clock);

    // Linear, defaults: every row = 4.5.
    fillConst(1024, 1024, 0, 0, 512);
    startRun(1'b1, 2'b00, 1'b1);
    waitDone(bc, yt);
    check("linear_busy_cycles", bc, 39);
    checkAllRows("linear_rows", 18'd4608);

    // Reset mid-run at column 10.
    fillConst(1024, 1024, 0, 0, 512);
    startRun(1'b1, 2'b00, 1'b1);
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkVec("midreset_gateOutput", gateOutput, '0);
    check("midreset_busy", busy, 0);
    check("midreset_dataReady", dataReady, 0);
    check("midreset_addrX", colAddressRead_X, 0);
    check("midreset_addrY", colAddressRead_Y, 0);
    void'(expQ.pop_back());
    modelOut = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    startRun(1'b1, 2'b00, 1'b1);
    waitDone(bc, yt);
    checkAllRows("after_reset_rows", 18'd4608);

    // Saturation, both signs.
    fillConst(131071, 131071, 131071, 131071, 0);
    startRun(1'b1, 2'b00, 1'b1);
    waitDone(bc, yt);
    checkAllRows("sat_positive", 18'h1FFFF);
    fillConst(131071, -131072, 131071, -131072, 0);
    startRun(1'b1, 2'b00, 1'b1);
    waitDone(bc, yt);
    checkAllRows("sat_negative", 18'h20000);

    // Activations with zero weights.
    fillConst(0, 0, 0, 0, 2048);   startRun(1'b1, 2'b01, 1'b1); waitDone(bc, yt);
    checkAllRows("hsig_plus2", 18'd1024);
    fillConst(0, 0, 0, 0, 0);      startRun(1'b1, 2'b01, 1'b1); waitDone(bc, yt);
    checkAllRows("hsig_zero", 18'd512);
    fillConst(0, 0, 0, 0, -4096);  startRun(1'b1, 2'b01, 1'b1); waitDone(bc, yt);
    checkAllRows("hsig_minus4", 18'd0);
    fillConst(0, 0, 0, 0, -3072);  startRun(1'b1, 2'b10, 1'b1); waitDone(bc, yt);
    checkAllRows("htanh_minus3", 18'h3FC00);
    fillConst(0, 0, 0, 0, 256);    startRun(1'b1, 2'b10, 1'b1); waitDone(bc, yt);
    checkAllRows("htanh_quarter", 18'd256);

    // useY=0 with nonzero recurrent data.
    fillConst(1024, 2048, 777, 999, 0);
    startRun(1'b0, 2'b00, 1'b1);
    waitDone(bc, yt);
    checkAllRows("noY_rows", 18'd8192);
    check("noY_busy_cycles", bc, 7);
    check("noY_addrY_static", yt, 0);

    // beginCalc during RUN_Y is ignored.
    fillRandom();
    startRun(1'b1, 2'b00, 1'b1);
    repeat (8) @(posedge clock);
    #1 beginCalc = 1'b1;
    repeat (6) @(posedge clock);
    #1 beginCalc = 1'b0;
    waitDone(bc, yt);

    // Abort at column 5.
    fillRandom();
    startRun(1'b1, 2'b00, 1'b1);
    repeat (5) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_addrX", colAddressRead_X, 0);
    check("abort_addrY", colAddressRead_Y, 0);
    void'(expQ.pop_back());
    repeat (50) @(negedge clock);
    checkVec("abort_output_held", gateOutput, modelOut);

    // abort and beginCalc together in IDLE: start dropped.
    abort = 1'b1; beginCalc = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0; beginCalc = 1'b0;
    check("abort_beats_start", busy, 0);
    repeat (45) @(negedge clock);

    // Back-to-back: start during the dataReady cycle.
    fillRandom();
    startRun(1'b1, 2'b01, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dataReady) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", seen, 1);
    fillRandom();
    startRun(1'b1, 2'b10, 1'b1);
    waitDone(bc, yt);
    check("b2b_busy_cycles", bc, 39);

    // Randomized runs.
    for (int k = 0; k < 12; k++) begin
      fillRandom();
      uy = 1'($urandom);
      md = 2'($urandom);
      repeat (rnd(0, 3)) @(negedge clock);
      startRun(uy, md, 1'b1);
      waitDone(bc, yt);
      check("rand_busy_cycles", bc, INPUT_SZ + (uy ? HIDDEN_SZ : 0) + 3);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gate_engine.md
# gate_engine

Column-serial LSTM gate engine: computes act(Wx·x + Wy·y + b) for HIDDEN_SZ rows in signed fixed point, streaming one input element and one weight column per cycle from two synchronous-read weight RAMs. Successor to `gate`, adding:
- selectable piecewise-linear activation;
- optional skip of the recurrent term (first timestep);
- saturating output;
- synchronous abort and a busy flag.

Sits between the weightRAM pair and the LSTM cell state/output logic.

## Interface
- INPUT_SZ, 4, length of x (columns of Wx)
- HIDDEN_SZ, 32, length of y and of the output (rows)
- QN, 7, integer bits
- QM, 10, fractional bits; BITWIDTH = QN+QM+1, two's complement
- Derived: LAYER_BITWIDTH = BITWIDTH*HIDDEN_SZ; AX = max(1,clog2(INPUT_SZ)); AY = max(1,clog2(HIDDEN_SZ))

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- beginCalc  in  1  start request, sampled in IDLE only
- abort  in  1  synchronous abort
- useY  in  1  1: include Wy·y; 0: skip Y columns; latched at start
- mode  in  2  00 linear, 01 hard-sigmoid, 10 hard-tanh, 11 = linear; latched at start
- biasVec  in  LAYER_BITWIDTH  row r at [r*BITWIDTH +: BITWIDTH]; sampled at start edge
- inputVec  in  BITWIDTH  x[colAddressRead_X], valid one cycle after address
- prevOutVec  in  BITWIDTH  y[colAddressRead_Y], valid one cycle after address
- weightMemOutput_X  in  LAYER_BITWIDTH  column of Wx, one cycle after address
- weightMemOutput_Y  in  LAYER_BITWIDTH  column of Wy, one cycle after address
- colAddressRead_X  out  AX  Wx/x column address
- colAddressRead_Y  out  AY  Wy/y column address
- busy  out  1  high from start edge until dataReady cycle
- dataReady  out  1  one-cycle pulse, gateOutput valid
- gateOutput  out  LAYER_BITWIDTH  registered result, held until next completion

## Operation
- States: IDLE, RUN_X, RUN_Y, DRAIN, FINISH.
- IDLE + beginCalc at edge E0:
  - acc[r] ← bias[r] << QM;
  - latch mode and useY;
  - go to RUN_X with colAddressRead_X = 0.
- RUN_X: address increments each edge; after INPUT_SZ-1, go to RUN_Y (useY=1) or DRAIN (useY=0).
- RUN_Y: same over 0..HIDDEN_SZ-1, then DRAIN.
- DRAIN: one cycle covering the RAM read latency, then FINISH.
- FINISH: write gateOutput, return to IDLE.
- Accumulation: each edge in which column data is valid, acc[r] += W[r][c] * v[c], where v is inputVec for X columns and prevOutVec for Y columns.
  - Products are full precision (2*BITWIDTH bits).
  - acc width is 2*BITWIDTH + clog2(INPUT_SZ+HIDDEN_SZ); no internal overflow.
- Output arithmetic:
  - s = acc >>> QM (floor), saturated to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
  - Activation, with ONE = 1<<QM:
    - linear: s;
    - hard-sigmoid: clamp((s>>>2) + ONE/2, 0, ONE);
    - hard-tanh: clamp(s, -ONE, ONE).
- Address outputs are 0 whenever not in RUN_X/RUN_Y; colAddressRead_Y stays 0 throughout when useY=0.
- All HIDDEN_SZ rows compute in parallel.

## Timing
- N = INPUT_SZ + (useY ? HIDDEN_SZ : 0).
- Column k address is registered at edge E(k) and its data is accumulated at E(k+2).
- gateOutput and dataReady are registered at E(N+2); dataReady is high for exactly the following cycle.
- busy is high from E0 through the dataReady cycle, then low.
- Defaults, useY=1: N = 36, dataReady registered at E38.
- beginCalc outside IDLE is ignored, no queuing.
- beginCalc high during the dataReady cycle (state IDLE) is accepted at the next edge; back-to-back throughput is N+3 cycles.
- abort in any non-IDLE state: go to IDLE at the next edge, no dataReady, gateOutput unchanged, busy low.
- abort and beginCalc together in IDLE: abort wins, start dropped.
- biasVec, mode and useY changes after E0 have no effect on the current computation.
- reset low, asynchronous and at any time, including mid-run:
  - state IDLE;
  - gateOutput = 0, dataReady = 0, busy = 0, both addresses = 0;
  - accumulators cleared.
- Release of reset is synchronous to clock.

## Test plan
1. Reset: pull reset low at column 10 of a run → all outputs 0 immediately; after release, a new start completes normally with correct result.
2. Linear, defaults, Wx=1.0 (1024), x=1.0, Wy=0, y=0, bias=0.5 (512), useY=1 → every row = 4608 (4.5); dataReady pulses exactly 38 edges after start; busy high 39 cycles.
3. Saturation: all W = 18'h1FFFF, x = y = 18'h1FFFF → rows 18'h1FFFF; with x = y = 18'h20000 → rows 18'h20000.
4. Activation, zero weights:
   - mode=01: bias 2.0 → 1024; bias 0 → 512; bias −4.0 → 0.
   - mode=10: bias −3.0 → 18'h3FC00 (−1024); bias 0.25 → 256.
5. useY=0 with nonzero Wy/y, Wx=1.0, x=2.0, bias=0 → rows 8192; latency 6 edges; colAddressRead_Y constant 0.
6. Control:
   - beginCalc during RUN_Y → ignored, result identical to a run without it.
   - abort at column 5 → IDLE next edge, no dataReady, gateOutput keeps prior value.
   - Start during the dataReady cycle → accepted, second result correct.
